// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder load/store slave.
// funct3 size codes, FSM state encoding and the byte-lane mask width live here.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int LANE_W = 4;

  // Reserved funct3 codes, and unsigned sizes used with a store, are illegal.
  function automatic logic size_illegal(input logic [2:0] size, input logic we);
    logic bad;
    bad = (size == 3'b011) || (size[2:1] == 2'b11) || (we && size[2]);
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering between a right-aligned core operand and a storage word.
// Halfword and word accesses always use the naturally aligned lanes inside the word.
module mem_lane_align
  import mem_resp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]        lane,
  input  logic [2:0]        size,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rword,
  output logic [LANE_W-1:0] be,
  output logic [XLEN-1:0]   wword,
  output logic [XLEN-1:0]   rdata
);

  logic signed [7:0]  rbyte;
  logic signed [15:0] rhalf;

  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = rword[{lane[1], 4'b0000} +: 16];

  always_comb begin
    be    = '0;
    wword = wdata;
    rdata = rword;
    case (size[1:0])
      2'b00: begin
        be    = LANE_W'(4'b0001 << lane);
        wword = {(XLEN/8){wdata[7:0]}};
        rdata = size[2] ? XLEN'($unsigned(rbyte)) : XLEN'(rbyte);
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {(XLEN/16){wdata[15:0]}};
        rdata = size[2] ? XLEN'($unsigned(rhalf)) : XLEN'(rhalf);
      end
      default: begin
        be    = '1;
        wword = wdata;
        rdata = rword;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding data-memory slave with fixed wait states and B/H/W lane handling.
// Define MEM_RESP_MISALIGN_EN to fault misaligned H/W accesses instead of force-aligning them.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [2:0]      size_i,
  output logic            ready_o,
  output logic            rvalid_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o,
  output logic            busy_o
);

  localparam int IDX_W    = $clog2(DEPTH);
  localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_p0;
  logic [XLEN-1:0]   addr_p0;
  logic [XLEN-1:0]   wdata_p0;
  logic [2:0]        size_p0;

  logic [XLEN-1:0]   mem [DEPTH];

  logic              acc_we;
  logic [XLEN-1:0]   acc_addr;
  logic [XLEN-1:0]   acc_wdata;
  logic [2:0]        acc_size;
  logic [IDX_W-1:0]  acc_idx;
  logic              range_err;
  logic              mis_err;
  logic              acc_err;
  logic              enter_resp;
  logic [LANE_W-1:0] be;
  logic [XLEN-1:0]   wword;
  logic [XLEN-1:0]   rword;
  logic [XLEN-1:0]   ext;
  logic [XLEN-1:0]   resp_rdata;

  assign ready_o = (state == IDLE) && !rst_i;
  assign busy_o  = (state != IDLE);

  // With zero wait states the access happens on the accept edge, before the latch is loaded.
  assign acc_we    = (state == IDLE) ? we_i    : we_p0;
  assign acc_addr  = (state == IDLE) ? addr_i  : addr_p0;
  assign acc_wdata = (state == IDLE) ? wdata_i : wdata_p0;
  assign acc_size  = (state == IDLE) ? size_i  : size_p0;

  assign acc_idx   = acc_addr[IDX_W+1:2];
  assign range_err = |(acc_addr >> (IDX_W + 2));

`ifdef MEM_RESP_MISALIGN_EN
  assign mis_err = ((acc_size[1:0] == 2'b01) && acc_addr[0]) ||
                   ((acc_size[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
`else
  assign mis_err = 1'b0;
`endif

  assign acc_err = range_err || mis_err || size_illegal(acc_size, acc_we);

  assign enter_resp = ((state == IDLE) && req_i && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == '0));

  assign rword = mem[acc_idx];

  mem_lane_align #(
    .XLEN (XLEN)
  ) u_align (
    .lane  (acc_addr[1:0]),
    .size  (acc_size),
    .wdata (acc_wdata),
    .rword (rword),
    .be    (be),
    .wword (wword),
    .rdata (ext)
  );

  assign resp_rdata = (acc_we || acc_err) ? '0 : ext;

  // Storage commit: on the edge entering RESP, suppressed by reset or fault.
  always_ff @(posedge clk_i) begin
    if (!rst_i && enter_resp && acc_we && !acc_err) begin
      for (int i = 0; i < LANE_W; i++) begin
        if (be[i]) mem[acc_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  // Request latch.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && req_i) begin
      we_p0    <= we_i;
      addr_p0  <= addr_i;
      wdata_p0 <= wdata_i;
      size_p0  <= size_i;
    end
  end

  // Control FSM and registered response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            if (WAIT_CYCLES == 0) begin
              state    <= RESP;
              rvalid_o <= 1'b1;
              rdata_o  <= resp_rdata;
              err_o    <= acc_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(CNT_INIT);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state    <= RESP;
            rvalid_o <= 1'b1;
            rdata_o  <= resp_rdata;
            err_o    <= acc_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, handshake/reset sequences, random ops vs a byte-array model.
// Honours MEM_RESP_MISALIGN_EN the same way as the design.
module tb_mem_responder;

  localparam int XLEN  = 32;
  localparam int DEPTH = 1024;
  localparam int WAITC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic [2:0]        size;
  logic              ready;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;
  logic              err;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_m [0:DEPTH*4-1];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t tbl[$];

  mem_responder #(
    .XLEN        (XLEN),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .size_i  (size),
    .ready_o (ready),
    .rvalid_o(rvalid),
    .rdata_o (rdata),
    .err_o   (err),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] s, output logic [31:0] rd, output logic er,
                        output int lat);
    int k;
    lat = -1;
    rd  = '0;
    er  = 1'b0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; size = s;
    k = 0;
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      req = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; size = 3'($urandom);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rvalid) begin
        lat = i;
        rd  = rdata;
        er  = err;
        break;
      end
    end
    if (lat < 0) begin
      check("rvalid_timeout", 32'd0, 32'd1);
      return;
    end
    @(negedge clk);
    check("rvalid_one_cycle", 32'(rvalid), 32'd0);
    check("rdata_hold", rdata, rd);
  endtask

  // Reference behaviour computed directly from the access rules on a byte array.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] s, output logic [31:0] rd, output logic er);
    int unsigned n;
    int unsigned base;
    logic [31:0] v;
    er = 1'b0;
    rd = '0;
    if (a >= DEPTH * 4) er = 1'b1;
    if (s == 3'd3 || s == 3'd6 || s == 3'd7) er = 1'b1;
    if (w && (s == 3'd4 || s == 3'd5)) er = 1'b1;
    n = (s[1:0] == 2'd0) ? 1 : (s[1:0] == 2'd1) ? 2 : 4;
    base = a;
`ifdef MEM_RESP_MISALIGN_EN
    if ((a % n) != 0) er = 1'b1;
`else
    base = a - (a % n);
`endif
    if (er) return;
    if (w) begin
      for (int i = 0; i < n; i++) mem_m[base + i] = d[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mem_m[base + i]) << (8 * i));
      if (!s[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
    end
  endtask

  logic [31:0] rd_got, rd_exp;
  logic        er_got, er_exp;
  int          lat;
  int          acc, rv, hsbad, seen;
  logic [2:0]  sz;
  logic [31:0] ra;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; size = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready",  32'(ready),  32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata",  rdata,       32'd0);
    check("rst_err",    32'(err),    32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(ready), 32'd1);

    // Directed vectors with hand-derived expectations.
    tbl.push_back('{1'b1, 32'h10,   32'hDEADBEEF, 3'b010, 32'h0,        1'b0, "st_w_10"});
    tbl.push_back('{1'b0, 32'h10,   32'h0,        3'b010, 32'hDEADBEEF, 1'b0, "ld_w_10"});
    tbl.push_back('{1'b1, 32'h20,   32'h11223344, 3'b010, 32'h0,        1'b0, "st_w_20"});
    tbl.push_back('{1'b1, 32'h21,   32'h00000080, 3'b000, 32'h0,        1'b0, "st_b_21"});
    tbl.push_back('{1'b0, 32'h21,   32'h0,        3'b000, 32'hFFFFFF80, 1'b0, "ld_b_21"});
    tbl.push_back('{1'b0, 32'h21,   32'h0,        3'b100, 32'h00000080, 1'b0, "ld_bu_21"});
    tbl.push_back('{1'b0, 32'h20,   32'h0,        3'b010, 32'h11228044, 1'b0, "ld_w_20"});
    tbl.push_back('{1'b1, 32'h32,   32'h00008001, 3'b001, 32'h0,        1'b0, "st_h_32"});
    tbl.push_back('{1'b0, 32'h32,   32'h0,        3'b001, 32'hFFFF8001, 1'b0, "ld_h_32"});
    tbl.push_back('{1'b0, 32'h32,   32'h0,        3'b101, 32'h00008001, 1'b0, "ld_hu_32"});
    tbl.push_back('{1'b0, 32'h1000, 32'h0,        3'b010, 32'h0,        1'b1, "ld_w_oor"});
    tbl.push_back('{1'b0, 32'h10,   32'h0,        3'b011, 32'h0,        1'b1, "ld_sz011"});
    tbl.push_back('{1'b1, 32'h10,   32'h55555555, 3'b100, 32'h0,        1'b1, "st_bu_err"});
    tbl.push_back('{1'b0, 32'h10,   32'h0,        3'b010, 32'hDEADBEEF, 1'b0, "ld_w_10_again"});
    tbl.push_back('{1'b1, 32'h40,   32'hAAAABBBB, 3'b010, 32'h0,        1'b0, "st_w_40"});
`ifdef MEM_RESP_MISALIGN_EN
    tbl.push_back('{1'b1, 32'h41,   32'hCAFEF00D, 3'b010, 32'h0,        1'b1, "st_w_41"});
    tbl.push_back('{1'b0, 32'h40,   32'h0,        3'b010, 32'hAAAABBBB, 1'b0, "ld_w_40"});
    tbl.push_back('{1'b0, 32'h33,   32'h0,        3'b001, 32'h0,        1'b1, "ld_h_33"});
`else
    tbl.push_back('{1'b1, 32'h41,   32'hCAFEF00D, 3'b010, 32'h0,        1'b0, "st_w_41"});
    tbl.push_back('{1'b0, 32'h40,   32'h0,        3'b010, 32'hCAFEF00D, 1'b0, "ld_w_40"});
    tbl.push_back('{1'b0, 32'h33,   32'h0,        3'b001, 32'hFFFF8001, 1'b0, "ld_h_33"});
`endif

    foreach (tbl[i]) begin
      do_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size, rd_got, er_got, lat);
      check({tbl[i].name, "_rdata"}, rd_got,       tbl[i].exp_rd);
      check({tbl[i].name, "_err"},   32'(er_got),  32'(tbl[i].exp_err));
      check({tbl[i].name, "_lat"},   32'(lat),     32'(WAITC + 1));
    end

    // Continuous request: one accept and one response every WAITC+2 cycles.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10; size = 3'b010;
    acc = 0; rv = 0; hsbad = 0;
    for (int i = 0; i < 4 * (WAITC + 2); i++) begin
      if (ready && req) acc++;
      if (rvalid) begin
        rv++;
        check("hs_rdata", rdata, 32'hDEADBEEF);
      end
      if (ready !== ((i % (WAITC + 2)) == 0)) hsbad++;
      if (rvalid !== ((i % (WAITC + 2)) == WAITC + 1)) hsbad++;
      if (busy !== !ready) hsbad++;
      @(negedge clk);
    end
    req = 1'b0;
    check("hs_accepts", 32'(acc),   32'd4);
    check("hs_rvalids", 32'(rv),    32'd4);
    check("hs_pattern", 32'(hsbad), 32'd0);

    // Reset one cycle after accepting a store: the store must be dropped.
    do_txn(1'b1, 32'h50, 32'h0BADF00D, 3'b010, rd_got, er_got, lat);
    @(negedge clk);
    check("rm_ready_pre", 32'(ready), 32'd1);
    req = 1'b1; we = 1'b1; addr = 32'h50; wdata = 32'h12345678; size = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; rst = 1'b1;
    seen = rvalid ? 1 : 0;
    @(negedge clk);
    if (rvalid) seen++;
    check("rm_ready_in_rst", 32'(ready), 32'd0);
    check("rm_busy_in_rst",  32'(busy),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    if (rvalid) seen++;
    check("rm_ready_after", 32'(ready), 32'd1);
    repeat (WAITC + 2) begin
      @(negedge clk);
      if (rvalid) seen++;
    end
    check("rm_no_rvalid", 32'(seen), 32'd0);
    do_txn(1'b0, 32'h50, 32'h0, 3'b010, rd_got, er_got, lat);
    check("rm_prior_data", rd_got, 32'h0BADF00D);

    // Random traffic against the byte-array model over a small initialised window.
    for (int w = 0; w < 16; w++) begin
      ra = $urandom;
      model(1'b1, 32'(w * 4), ra, 3'b010, rd_exp, er_exp);
      do_txn(1'b1, 32'(w * 4), ra, 3'b010, rd_got, er_got, lat);
      check("init_err", 32'(er_got), 32'(er_exp));
    end
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       sz = 3'($urandom_range(0, 7));
        1, 2:    sz = 3'b000;
        3, 4:    sz = 3'b001;
        5, 6:    sz = 3'b010;
        7:       sz = 3'b100;
        default: sz = 3'b101;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h1000 | $urandom;
      else ra = 32'($urandom_range(0, 63));
      wdata = $urandom;
      ra = ra;
      begin
        logic        w_r;
        logic [31:0] d_r;
        w_r = 1'($urandom_range(0, 1));
        d_r = $urandom;
        model(w_r, ra, d_r, sz, rd_exp, er_exp);
        do_txn(w_r, ra, d_r, sz, rd_got, er_got, lat);
        check($sformatf("rnd%0d_rdata_a%h_s%0d_w%0d", n, ra, sz, w_r), rd_got, rd_exp);
        check($sformatf("rnd%0d_err", n), 32'(er_got), 32'(er_exp));
        check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(WAITC + 1));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
